// File: rtl/bk_mem_arbiter.sv
// Purpose: arbitrates the single 16-bit SRAM between the bkcore CPU bus and the video fetcher.
// Latency: CPU rdy MEM_WAIT+1 clocks on an idle bus; video ack within 3*MEM_WAIT+3 clocks.
// Backpressure: requests are levels held until cpu_rdy / vid_ack; optional refresh via ARB_REFRESH_EN.
module bk_mem_arbiter #(
   parameter int MEM_WAIT = 2
`ifdef ARB_REFRESH_EN
  ,parameter int REF_DIV  = 64
`endif
) (
   input  logic        m_clock,
   input  logic        reset_n,
   input  logic        cpu_rd,
   input  logic        cpu_wt,
   input  logic        cpu_byte,
   input  logic [15:0] cpu_adr,
   input  logic [15:0] cpu_wdata,
   output logic [15:0] cpu_rdata,
   output logic        cpu_rdy,
   input  logic        vid_req,
   input  logic [14:0] vid_adr,
   output logic        vid_ack,
   output logic [15:0] vid_data,
   output logic [14:0] mem_adr,
   output logic [1:0]  mem_be,
   output logic        mem_oe,
   output logic        mem_we,
   output logic [15:0] mem_dout,
   input  logic [15:0] mem_din
);

   typedef enum logic [2:0] {
      IDLE,
      CPU_ACC,
      VID_ACC,
      CPU_HOLD
`ifdef ARB_REFRESH_EN
     ,REF
`endif
   } state_t;

   localparam logic [2:0] ACC_LAST = 3'(MEM_WAIT - 1);

   state_t     state;
   logic [2:0] cnt;
   logic       last_vid;
   logic       ref_pend;

   logic cpu_req;
   logic cpu_elig;
   logic bus_free;
   logic acc_last;
   logic grant_ref;
   logic grant_vid;
   logic grant_cpu;

   // Grant decision: refresh first, then video, except the CPU goes first right after a video grant.
   always_comb begin
      cpu_req   = cpu_rd | cpu_wt;
      cpu_elig  = cpu_req & ~cpu_adr[15] & ~cpu_rdy;
      bus_free  = (state == IDLE) || (state == CPU_HOLD);
      acc_last  = (cnt == ACC_LAST);
      grant_ref = bus_free & ref_pend;
      grant_cpu = bus_free & ~ref_pend & cpu_elig & (last_vid | ~vid_req);
      grant_vid = bus_free & ~ref_pend & vid_req & ~(cpu_elig & last_vid);
   end

`ifdef ARB_REFRESH_EN
   localparam int             RW       = (REF_DIV > 1) ? $clog2(REF_DIV) : 1;
   localparam logic [RW-1:0]  REF_LAST = RW'(REF_DIV - 1);
   logic [RW-1:0] ref_cnt;

   // Free-running divider raises one refresh request per REF_DIV clocks; taking the slot clears it.
   always_ff @(posedge m_clock or negedge reset_n) begin
      if (!reset_n) begin
         ref_cnt  <= '0;
         ref_pend <= 1'b0;
      end else begin
         if (grant_ref) ref_pend <= 1'b0;
         if (ref_cnt == REF_LAST) begin
            ref_cnt  <= '0;
            ref_pend <= 1'b1;
         end else begin
            ref_cnt <= ref_cnt + 1'b1;
         end
      end
   end
`else
   assign ref_pend = 1'b0;
`endif

   // Access sequencer: all SRAM strobes, addresses and captured data are registered here.
   always_ff @(posedge m_clock or negedge reset_n) begin
      if (!reset_n) begin
         state     <= IDLE;
         cnt       <= 3'd0;
         last_vid  <= 1'b0;
         cpu_rdy   <= 1'b0;
         cpu_rdata <= 16'h0000;
         vid_ack   <= 1'b0;
         vid_data  <= 16'h0000;
         mem_adr   <= 15'h0000;
         mem_be    <= 2'b00;
         mem_oe    <= 1'b0;
         mem_we    <= 1'b0;
         mem_dout  <= 16'h0000;
      end else begin
         vid_ack <= 1'b0;
         if (!cpu_req) cpu_rdy <= 1'b0;
         case (state)
            IDLE, CPU_HOLD: begin
               cnt <= 3'd0;
`ifdef ARB_REFRESH_EN
               if (grant_ref) begin
                  state  <= REF;
                  mem_be <= 2'b00;
               end else
`endif
               if (grant_vid) begin
                  state    <= VID_ACC;
                  mem_adr  <= vid_adr;
                  mem_be   <= 2'b11;
                  mem_oe   <= 1'b1;
                  last_vid <= 1'b1;
               end else if (grant_cpu) begin
                  state    <= CPU_ACC;
                  mem_adr  <= cpu_adr[15:1];
                  mem_be   <= cpu_byte ? (cpu_adr[0] ? 2'b10 : 2'b01) : 2'b11;
                  last_vid <= 1'b0;
                  // A simultaneous read and write is taken as a write.
                  if (cpu_wt) begin
                     mem_we   <= 1'b1;
                     mem_dout <= cpu_wdata;
                  end else begin
                     mem_oe <= 1'b1;
                  end
               end else if ((state == CPU_HOLD) && !cpu_req) begin
                  state <= IDLE;
               end
            end
            CPU_ACC: begin
               if (acc_last) begin
                  if (mem_oe) cpu_rdata <= mem_din;
                  mem_oe  <= 1'b0;
                  mem_we  <= 1'b0;
                  cpu_rdy <= 1'b1;
                  state   <= CPU_HOLD;
               end else begin
                  cnt <= cnt + 3'd1;
               end
            end
            VID_ACC: begin
               if (acc_last) begin
                  vid_data <= mem_din;
                  vid_ack  <= 1'b1;
                  mem_oe   <= 1'b0;
                  state    <= (cpu_rdy && cpu_req) ? CPU_HOLD : IDLE;
               end else begin
                  cnt <= cnt + 3'd1;
               end
            end
`ifdef ARB_REFRESH_EN
            REF: begin
               if (acc_last) begin
                  state <= (cpu_rdy && cpu_req) ? CPU_HOLD : IDLE;
               end else begin
                  cnt <= cnt + 3'd1;
               end
            end
`endif
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_bk_mem_arbiter.sv
// Purpose: directed bench for bk_mem_arbiter: CPU access table, arbitration order, reset, refresh.
// Latency: expects CPU rdy MEM_WAIT+1 clocks after request on an idle bus.
// Backpressure: requests held as levels until rdy/ack, then dropped by the bench.
module tb_bk_mem_arbiter;

   localparam int MW = 2;

   logic        m_clock = 1'b0;
   logic        reset_n = 1'b0;
   logic        cpu_rd = 1'b0, cpu_wt = 1'b0, cpu_byte = 1'b0;
   logic [15:0] cpu_adr = 16'h0, cpu_wdata = 16'h0;
   logic [15:0] cpu_rdata;
   logic        cpu_rdy;
   logic        vid_req = 1'b0;
   logic [14:0] vid_adr = 15'h0;
   logic        vid_ack;
   logic [15:0] vid_data;
   logic [14:0] mem_adr;
   logic [1:0]  mem_be;
   logic        mem_oe, mem_we;
   logic [15:0] mem_dout;
   logic [15:0] mem_din;

   logic        use_model = 1'b0;
   logic [15:0] din_vec = 16'h0;

   // SRAM stand-in: either a fixed word from the vector table or a pattern derived from the address.
   assign mem_din = use_model ? ({1'b0, mem_adr} ^ 16'hC3C3) : din_vec;

   always #5 m_clock = ~m_clock;

   bk_mem_arbiter #(
      .MEM_WAIT(MW)
`ifdef ARB_REFRESH_EN
     ,.REF_DIV(16)
`endif
   ) dut (
      .m_clock(m_clock), .reset_n(reset_n),
      .cpu_rd(cpu_rd), .cpu_wt(cpu_wt), .cpu_byte(cpu_byte),
      .cpu_adr(cpu_adr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_rdy(cpu_rdy),
      .vid_req(vid_req), .vid_adr(vid_adr), .vid_ack(vid_ack), .vid_data(vid_data),
      .mem_adr(mem_adr), .mem_be(mem_be), .mem_oe(mem_oe), .mem_we(mem_we),
      .mem_dout(mem_dout), .mem_din(mem_din)
   );

   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   typedef struct {
      logic        rd;
      logic        wt;
      logic        byt;
      logic [15:0] adr;
      logic [15:0] wdata;
      logic [15:0] din;
      logic        rom;
      logic [14:0] e_adr;
      logic [1:0]  e_be;
      logic [15:0] e_data;
   } vec_t;

   vec_t vecs [6];

   task automatic tick();
      @(posedge m_clock);
      @(negedge m_clock);
   endtask

   task automatic run_vec(input vec_t v);
      int   lat = 0, oe_n = 0, we_n = 0;
      logic got = 1'b0, adr_moved = 1'b0, seen = 1'b0;
      logic [14:0] adr_s = '0;
      logic [1:0]  be_s = '0;
      logic [15:0] dout_s = '0;
      cpu_rd = v.rd; cpu_wt = v.wt; cpu_byte = v.byt;
      cpu_adr = v.adr; cpu_wdata = v.wdata; din_vec = v.din;
      for (int c = 0; c < 12 && !got; c++) begin
         tick();
         if (mem_oe) oe_n++;
         if (mem_we) we_n++;
         if (mem_oe || mem_we) begin
            if (seen && (mem_adr != adr_s)) adr_moved = 1'b1;
            seen = 1'b1;
            adr_s = mem_adr; be_s = mem_be; dout_s = mem_dout;
         end
         if (cpu_rdy) begin
            got = 1'b1;
            lat = c + 1;
         end
      end
      if (v.rom) begin
         check("rom_no_rdy", {31'd0, got}, 32'd0);
         check("rom_no_strobe", oe_n + we_n, 32'd0);
      end else begin
`ifdef ARB_REFRESH_EN
         check("cpu_latency_bound", {31'd0, (lat >= MW + 1) && (lat <= 2 * MW + 2)}, 32'd1);
`else
         check("cpu_latency", lat, MW + 1);
`endif
         check("cpu_mem_adr", {17'd0, adr_s}, {17'd0, v.e_adr});
         check("cpu_adr_stable", {31'd0, adr_moved}, 32'd0);
         check("cpu_mem_be", {30'd0, be_s}, {30'd0, v.e_be});
         if (v.wt) begin
            check("wr_we_clocks", we_n, MW);
            check("wr_no_oe", oe_n, 0);
            check("wr_dout", {16'd0, dout_s}, {16'd0, v.e_data});
            check("wr_we_low_at_rdy", {31'd0, mem_we}, 32'd0);
         end else begin
            check("rd_oe_clocks", oe_n, MW);
            check("rd_no_we", we_n, 0);
            check("rd_data", {16'd0, cpu_rdata}, {16'd0, v.e_data});
         end
      end
      cpu_rd = 1'b0; cpu_wt = 1'b0;
      tick();
      check("rdy_drop", {31'd0, cpu_rdy}, 32'd0);
      tick();
   endtask

   // Directed sequence: reset, CPU vector table, arbitration order, reset mid-access, refresh spacing.
   initial begin
      int ev [$];
      int run, max_run, ord;
      logic rdy_p;
      logic [15:0] rd_at_rdy, exp_cpu;

      //                 rd    wt    byt   adr         wdata     din       rom   e_adr       e_be   e_data
      vecs[0] = '{1'b1, 1'b0, 1'b0, 16'o001000, 16'h0000, 16'h1234, 1'b0, 15'o000400, 2'b11, 16'h1234};
      vecs[1] = '{1'b0, 1'b1, 1'b1, 16'o000401, 16'hA5A5, 16'h0000, 1'b0, 15'o000200, 2'b10, 16'hA5A5};
      vecs[2] = '{1'b1, 1'b0, 1'b1, 16'o000400, 16'h0000, 16'hBEEF, 1'b0, 15'o000200, 2'b01, 16'hBEEF};
      vecs[3] = '{1'b0, 1'b1, 1'b0, 16'o077776, 16'h5A5A, 16'h0000, 1'b0, 15'o037777, 2'b11, 16'h5A5A};
      vecs[4] = '{1'b1, 1'b1, 1'b0, 16'o000002, 16'h1357, 16'hFFFF, 1'b0, 15'o000001, 2'b11, 16'h1357};
      vecs[5] = '{1'b1, 1'b0, 1'b0, 16'o100000, 16'h0000, 16'h7777, 1'b1, 15'o000000, 2'b00, 16'h0000};

      repeat (3) tick();
      check("rst_ctrl", {26'd0, cpu_rdy, vid_ack, mem_oe, mem_we, mem_be}, 32'd0);
      check("rst_adr", {17'd0, mem_adr}, 32'd0);
      check("rst_data", {cpu_rdata, vid_data}, 32'd0);
      reset_n = 1'b1;
      tick();

      for (int i = 0; i < 6; i++) run_vec(vecs[i]);

      // Video and CPU together with video held: expect video, CPU, video.
      use_model = 1'b1;
      vid_adr = 15'h1234;
      cpu_adr = 16'o002000; cpu_byte = 1'b0; cpu_rd = 1'b1; vid_req = 1'b1;
      exp_cpu = {1'b0, 15'o001000} ^ 16'hC3C3;
      run = 0; max_run = 0; rdy_p = 1'b0; rd_at_rdy = 16'h0;
      for (int c = 0; c < 40 && ev.size() < 3; c++) begin
         tick();
         if (vid_ack) begin
            run++;
            ev.push_back(1);
            check("t4_vid_data", {16'd0, vid_data}, {16'd0, {1'b0, vid_adr} ^ 16'hC3C3});
            vid_adr = vid_adr + 15'h0101;
         end else begin
            run = 0;
         end
         if (run > max_run) max_run = run;
         if (cpu_rdy && !rdy_p) begin
            ev.push_back(2);
            rd_at_rdy = cpu_rdata;
            check("t4_cpu_rdata", {16'd0, cpu_rdata}, {16'd0, exp_cpu});
         end
         rdy_p = cpu_rdy;
      end
      tick();
      check("t4_ack_single", {31'd0, vid_ack}, 32'd0);
      check("t4_ack_width", max_run, 1);
      check("t4_events", ev.size(), 3);
      ord = (ev.size() == 3) ? (ev[0] * 100 + ev[1] * 10 + ev[2]) : 0;
      check("t4_order", ord, 121);
      check("t4_rdy_held", {31'd0, cpu_rdy}, 32'd1);
      check("t4_rdata_held", {16'd0, cpu_rdata}, {16'd0, rd_at_rdy});
      cpu_rd = 1'b0; vid_req = 1'b0;
      repeat (2 * MW + 3) tick();
      check("t4_idle", {30'd0, cpu_rdy, mem_oe}, 32'd0);

      // Reset in the middle of a CPU read.
      use_model = 1'b0;
      din_vec = 16'h4321;
      cpu_adr = 16'o001000; cpu_rd = 1'b1;
      tick();
      check("t5_oe_active", {31'd0, mem_oe}, 32'd1);
      reset_n = 1'b0;
      #1;
      check("t5_ctrl", {26'd0, cpu_rdy, vid_ack, mem_oe, mem_we, mem_be}, 32'd0);
      check("t5_adr", {17'd0, mem_adr}, 32'd0);
      check("t5_dout", {16'd0, mem_dout}, 32'd0);
      check("t5_data", {cpu_rdata, vid_data}, 32'd0);
      cpu_rd = 1'b0;
      repeat (3) tick();
      check("t5_still_rst", {30'd0, cpu_rdy, mem_oe}, 32'd0);
      reset_n = 1'b1;
      tick();
      run_vec(vecs[0]);

`ifdef ARB_REFRESH_EN
      begin
         int   last_start, nref, oe_run;
         logic ref_p, ref_now;
         use_model = 1'b1;
         vid_adr = 15'h0040;
         vid_req = 1'b1;
         last_start = -1; nref = 0; oe_run = 0; ref_p = 1'b0;
         for (int c = 0; c < 300; c++) begin
            tick();
            ref_now = !mem_oe && !mem_we && (mem_be == 2'b00);
            if (ref_now && !ref_p) begin
               if (last_start >= 0)
                  check("t6_ref_spacing", {31'd0, (c - last_start >= 16 - (MW + 1)) &&
                                                  (c - last_start <= 16 + (MW + 1))}, 32'd1);
               last_start = c;
               nref++;
            end
            ref_p = ref_now;
            if (mem_oe) begin
               oe_run++;
            end else if (oe_run != 0) begin
               check("t6_access_len", oe_run, MW);
               oe_run = 0;
            end
         end
         check("t6_ref_count", {31'd0, nref >= 15}, 32'd1);
         vid_req = 1'b0;
         repeat (2 * MW + 3) tick();
      end
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
